// File: rtl/memory_unit.sv
// Memory unit of the 8-bit core: unified program/data RAM, PC and MAR.
// Reads are combinational; all state updates happen on posedge.
module memory_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  halt,
   input  logic [2:0]            memory_op,
   input  logic                  data_word_selector,
   input  logic                  bus_selector,
   input  logic [7:0]            bus_in,
   output logic [7:0]            bus_out,
   output logic                  bus_drive,
   input  logic                  prog_we,
   input  logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [7:0]            prog_data,
   output logic [ADDR_WIDTH-1:0] pc
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      OP_NOP,
      OP_FETCH,
      OP_READ,
      OP_WRITE,
      OP_LD_MAR,
      OP_JUMP,
      OP_PC_OUT,
      OP_RSVD
   } memory_op_e;

   memory_op_e            op;
   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] mar;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] pc_inc;

   assign op     = memory_op_e'(memory_op);
   assign addr   = data_word_selector ? pc : mar;
   assign pc_inc = pc + ADDR_WIDTH'(1);

   always_comb begin
      bus_out   = 8'h00;
      bus_drive = 1'b0;
      if (bus_selector && !halt) begin
         unique case (op)
            OP_FETCH: begin
               bus_out   = mem[pc];
               bus_drive = 1'b1;
            end
            OP_READ: begin
               bus_out   = mem[addr];
               bus_drive = 1'b1;
            end
            OP_PC_OUT: begin
               bus_out   = 8'(pc);
               bus_drive = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc  <= RESET_PC;
         mar <= '0;
      end else if (!halt) begin
         unique case (op)
            OP_FETCH:  pc  <= pc_inc;
            OP_READ,
            OP_WRITE:  if (data_word_selector) pc <= pc_inc;
            OP_LD_MAR: mar <= ADDR_WIDTH'(bus_in);
            OP_JUMP:   pc  <= ADDR_WIDTH'(bus_in);
            default: ;
         endcase
      end
   end

   // RAM is never cleared; reset only suppresses a write in its own cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (halt) begin
            if (prog_we) mem[prog_addr] <= prog_data;
         end else if (op == OP_WRITE) begin
            mem[addr] <= bus_in;
         end
      end
   end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: expected bus values are queued when a
// step is driven and popped when the combinational output is sampled.
module tb_memory_unit;

   localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, READ = 3'd2;
   localparam logic [2:0] WRITE = 3'd3, LD_MAR = 3'd4, JUMP = 3'd5;
   localparam logic [2:0] PC_OUT = 3'd6;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       halt = 1'b0;
   logic [2:0] memory_op = NOP;
   logic       data_word_selector = 1'b0;
   logic       bus_selector = 1'b0;
   logic [7:0] bus_in = 8'h00;
   logic [7:0] bus_out;
   logic       bus_drive;
   logic       prog_we = 1'b0;
   logic [7:0] prog_addr = 8'h00;
   logic [7:0] prog_data = 8'h00;
   logic [7:0] pc;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic       drive;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   memory_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clock(clock),
      .reset(reset),
      .halt(halt),
      .memory_op(memory_op),
      .data_word_selector(data_word_selector),
      .bus_selector(bus_selector),
      .bus_in(bus_in),
      .bus_out(bus_out),
      .bus_drive(bus_drive),
      .prog_we(prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data),
      .pc(pc)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One core cycle: drive at negedge, sample mid-low phase, then posedge.
   task automatic step(input string tag, input logic [2:0] op,
                       input logic dws, input logic bsel,
                       input logic [7:0] bin, input logic exp_drive,
                       input logic [7:0] exp_data);
      exp_t e;
      @(negedge clock);
      memory_op = op;
      data_word_selector = dws;
      bus_selector = bsel;
      bus_in = bin;
      sb.push_back('{drive: exp_drive, data: exp_data});
      #1;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".drive"}, {7'd0, bus_drive}, {7'd0, e.drive});
         chk({tag, ".data"}, bus_out, e.data);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic prog(input logic [7:0] a, input logic [7:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = d;
      step("prog", NOP, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      prog_we = 1'b0;
   endtask

   initial begin
      step("rst0", NOP, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      step("rst1", NOP, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      chk("rst_pc", pc, 8'h00);

      reset = 1'b0;
      halt = 1'b1;
      prog(8'h00, 8'hA5);
      prog(8'h01, 8'h3C);
      prog(8'h10, 8'h77);
      prog(8'h20, 8'h99);
      prog(8'hFF, 8'hEE);
      halt = 1'b0;
      reset = 1'b1;
      step("rst2", NOP, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      reset = 1'b0;
      chk("pc_after_rst", pc, 8'h00);

      step("fetch0", FETCH, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
      step("fetch1", FETCH, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C);
      chk("pc_fetch", pc, 8'h02);

      step("ldmar", LD_MAR, 1'b0, 1'b1, 8'h80, 1'b0, 8'h00);
      step("write", WRITE, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
      step("read", READ, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A);
      chk("pc_rw", pc, 8'h02);
      step("pcout", PC_OUT, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02);
      step("nop_bsel", NOP, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      step("rsvd", 3'd7, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);

      step("jump_ff", JUMP, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
      chk("pc_jump", pc, 8'hFF);
      step("fetch_ff", FETCH, 1'b0, 1'b1, 8'h00, 1'b1, 8'hEE);
      chk("pc_wrap", pc, 8'h00);
      step("fetch_00", FETCH, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
      chk("pc_wrap1", pc, 8'h01);

      step("jump_10", JUMP, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00);
      step("read_pc", READ, 1'b1, 1'b1, 8'h00, 1'b1, 8'h77);
      chk("pc_read_inc", pc, 8'h11);
      step("jump_10b", JUMP, 1'b0, 1'b0, 8'h10, 1'b0, 8'h00);
      step("read_nobus", READ, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("pc_nobus_inc", pc, 8'h11);

      step("ldmar20", LD_MAR, 1'b0, 1'b0, 8'h20, 1'b0, 8'h00);
      reset = 1'b1;
      step("rst_write", WRITE, 1'b0, 1'b0, 8'h55, 1'b0, 8'h00);
      step("rst_jump", JUMP, 1'b0, 1'b0, 8'h40, 1'b0, 8'h00);
      reset = 1'b0;
      chk("pc_rst_mid", pc, 8'h00);
      step("read_mar0", READ, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
      step("jump_20", JUMP, 1'b0, 1'b0, 8'h20, 1'b0, 8'h00);
      step("read_20", READ, 1'b1, 1'b1, 8'h00, 1'b1, 8'h99);
      chk("pc_21", pc, 8'h21);

      halt = 1'b1;
      prog_we = 1'b1;
      prog_addr = 8'h05;
      prog_data = 8'hC3;
      step("halt_fetch", FETCH, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      prog_we = 1'b0;
      chk("pc_halt", pc, 8'h21);
      step("halt_ldmar", LD_MAR, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00);
      step("halt_jump", JUMP, 1'b0, 1'b1, 8'h44, 1'b0, 8'h00);
      chk("pc_halt2", pc, 8'h21);
      halt = 1'b0;
      step("read_mar_hold", READ, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);

      prog_we = 1'b1;
      prog_addr = 8'h05;
      prog_data = 8'h00;
      step("prog_ignored", NOP, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      prog_we = 1'b0;
      step("jump_05", JUMP, 1'b0, 1'b0, 8'h05, 1'b0, 8'h00);
      step("read_05", READ, 1'b1, 1'b1, 8'h00, 1'b1, 8'hC3);
      chk("pc_06", pc, 8'h06);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
